// File: rtl/atm_rx_cell_filter_if.sv
// UTOPIA Level 1 receive handshake plus the valid/ready cell byte stream toward the forwarding engine.
// master = the cell filter, slave = PHY / forwarding-engine side.
interface atm_rx_cell_filter_if;
    logic [7:0] rx_data;
    logic       rx_soc;
    logic       rx_en_n;
    logic       rx_clav;
    logic [7:0] out_data;
    logic       out_soc;
    logic       out_valid;
    logic       out_ready;

    modport master (
        input  rx_data, rx_soc, rx_clav, out_ready,
        output rx_en_n, out_data, out_soc, out_valid
    );

    modport slave (
        output rx_data, rx_soc, rx_clav, out_ready,
        input  rx_en_n, out_data, out_soc, out_valid
    );
endinterface

// File: rtl/atm_rx_cell_filter.sv
// ATM UTOPIA L1 Rx stage: two-slot 53-byte cell buffer, HEC check, runt abort, byte-stream output.
// Optional idle/unassigned cell discard is enabled by defining ATM_RX_IDLE_FILTER_EN.
module atm_rx_cell_filter #(
    parameter int unsigned CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    atm_rx_cell_filter_if.master bus,
    output logic [CNT_W-1:0]     cell_cnt,
    output logic [CNT_W-1:0]     hec_err_cnt,
    output logic [CNT_W-1:0]     runt_cnt
`ifdef ATM_RX_IDLE_FILTER_EN
    ,
    output logic [CNT_W-1:0]     idle_cnt
`endif
);
    localparam int unsigned      CELL_LEN  = 53;
    localparam int unsigned      IDX_W     = 6;
    localparam int unsigned      OCC_W     = 2;
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(CELL_LEN - 1);
    localparam logic [IDX_W-1:0] HEC_IDX   = IDX_W'(4);
    localparam logic [7:0]       HEC_COSET = 8'h55;
    localparam logic [OCC_W-1:0] OCC_FULL  = OCC_W'(2);

    typedef enum logic [1:0] {ST_IDLE, ST_HUNT, ST_RECV} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [7:0]       crc_q, crc_d;
    logic             hec_ok_q, hec_ok_d;
    logic             rx_en_n_q, rx_en_n_d;
    logic             wr_slot_q, wr_slot_d;
    logic             rd_slot_q, rd_slot_d;
    logic [IDX_W-1:0] rd_idx_q, rd_idx_d;
    logic [OCC_W-1:0] occ_q, occ_d;
    logic [7:0]       out_data_q, out_data_d;
    logic             out_soc_q, out_soc_d;
    logic             out_valid_q, out_valid_d;
    logic [CNT_W-1:0] cell_cnt_q, cell_cnt_d;
    logic [CNT_W-1:0] hec_err_cnt_q, hec_err_cnt_d;
    logic [CNT_W-1:0] runt_cnt_q, runt_cnt_d;
`ifdef ATM_RX_IDLE_FILTER_EN
    logic             idle_hdr_q, idle_hdr_d;
    logic [CNT_W-1:0] idle_cnt_q, idle_cnt_d;
`endif

    logic [7:0]       mem_q [2][CELL_LEN];
    logic             mem_we;
    logic [IDX_W-1:0] mem_widx;
    logic             accept;
    logic             commit;
    logic             fire;
    logic             free;

    // CRC-8, polynomial 0x07, MSB first, one byte per call.
    function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
        end
        return c;
    endfunction

    // Receive FSM: hunt for SOC, write bytes, judge the cell at byte 52.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        crc_d         = crc_q;
        hec_ok_d      = hec_ok_q;
        mem_we        = 1'b0;
        mem_widx      = idx_q;
        commit        = 1'b0;
        cell_cnt_d    = cell_cnt_q;
        hec_err_cnt_d = hec_err_cnt_q;
        runt_cnt_d    = runt_cnt_q;
        accept        = !rx_en_n_q;
`ifdef ATM_RX_IDLE_FILTER_EN
        idle_hdr_d    = idle_hdr_q;
        idle_cnt_d    = idle_cnt_q;
`endif
        if (state_q == ST_IDLE) begin
            if (bus.rx_clav && occ_q != OCC_FULL) begin
                state_d = ST_HUNT;
            end
        end else if (accept) begin
            if (bus.rx_soc) begin
                // A SOC inside RECV aborts the partial cell and restarts the same slot.
                mem_we   = 1'b1;
                mem_widx = '0;
                idx_d    = IDX_W'(1);
                crc_d    = crc8_step(8'h00, bus.rx_data);
                state_d  = ST_RECV;
                if (state_q == ST_RECV) begin
                    runt_cnt_d = runt_cnt_q + CNT_W'(1);
                end
`ifdef ATM_RX_IDLE_FILTER_EN
                idle_hdr_d = (bus.rx_data == 8'h00);
`endif
            end else if (state_q == ST_RECV) begin
                mem_we = 1'b1;
                if (idx_q < HEC_IDX) begin
                    crc_d = crc8_step(crc_q, bus.rx_data);
                end
                if (idx_q == HEC_IDX) begin
                    hec_ok_d = ((crc_q ^ HEC_COSET) == bus.rx_data);
                end
`ifdef ATM_RX_IDLE_FILTER_EN
                if (idx_q == IDX_W'(1) || idx_q == IDX_W'(2)) begin
                    idle_hdr_d = idle_hdr_q && (bus.rx_data == 8'h00);
                end
                if (idx_q == IDX_W'(3)) begin
                    idle_hdr_d = idle_hdr_q && (bus.rx_data[7:1] == 7'h00);
                end
`endif
                if (idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    idx_d   = '0;
                    if (!hec_ok_q) begin
                        hec_err_cnt_d = hec_err_cnt_q + CNT_W'(1);
                    end
`ifdef ATM_RX_IDLE_FILTER_EN
                    else if (idle_hdr_q) begin
                        idle_cnt_d = idle_cnt_q + CNT_W'(1);
                    end
`endif
                    else begin
                        commit     = 1'b1;
                        cell_cnt_d = cell_cnt_q + CNT_W'(1);
                    end
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
        end
        rx_en_n_d = (state_d == ST_IDLE);
    end

    // Output side: read slot walk, occupancy, and the registered byte presented downstream.
    always_comb begin
        fire      = out_valid_q && bus.out_ready;
        free      = fire && (rd_idx_q == LAST_IDX);
        rd_idx_d  = rd_idx_q;
        rd_slot_d = rd_slot_q;
        if (fire) begin
            if (free) begin
                rd_idx_d  = '0;
                rd_slot_d = ~rd_slot_q;
            end else begin
                rd_idx_d = rd_idx_q + IDX_W'(1);
            end
        end
        wr_slot_d   = commit ? ~wr_slot_q : wr_slot_q;
        occ_d       = occ_q + OCC_W'(commit) - OCC_W'(free);
        out_valid_d = (occ_d != '0);
        out_data_d  = out_valid_d ? mem_q[rd_slot_d][rd_idx_d] : 8'h00;
        out_soc_d   = out_valid_d && (rd_idx_d == '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            idx_q         <= '0;
            crc_q         <= '0;
            hec_ok_q      <= 1'b0;
            rx_en_n_q     <= 1'b1;
            wr_slot_q     <= 1'b0;
            rd_slot_q     <= 1'b0;
            rd_idx_q      <= '0;
            occ_q         <= '0;
            out_data_q    <= 8'h00;
            out_soc_q     <= 1'b0;
            out_valid_q   <= 1'b0;
            cell_cnt_q    <= '0;
            hec_err_cnt_q <= '0;
            runt_cnt_q    <= '0;
`ifdef ATM_RX_IDLE_FILTER_EN
            idle_hdr_q    <= 1'b0;
            idle_cnt_q    <= '0;
`endif
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            crc_q         <= crc_d;
            hec_ok_q      <= hec_ok_d;
            rx_en_n_q     <= rx_en_n_d;
            wr_slot_q     <= wr_slot_d;
            rd_slot_q     <= rd_slot_d;
            rd_idx_q      <= rd_idx_d;
            occ_q         <= occ_d;
            out_data_q    <= out_data_d;
            out_soc_q     <= out_soc_d;
            out_valid_q   <= out_valid_d;
            cell_cnt_q    <= cell_cnt_d;
            hec_err_cnt_q <= hec_err_cnt_d;
            runt_cnt_q    <= runt_cnt_d;
`ifdef ATM_RX_IDLE_FILTER_EN
            idle_hdr_q    <= idle_hdr_d;
            idle_cnt_q    <= idle_cnt_d;
`endif
        end
    end

    // Cell storage carries no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem_q[wr_slot_q][mem_widx] <= bus.rx_data;
        end
    end

    assign bus.rx_en_n   = rx_en_n_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_soc   = out_soc_q;
    assign bus.out_valid = out_valid_q;
    assign cell_cnt      = cell_cnt_q;
    assign hec_err_cnt   = hec_err_cnt_q;
    assign runt_cnt      = runt_cnt_q;
`ifdef ATM_RX_IDLE_FILTER_EN
    assign idle_cnt      = idle_cnt_q;
`endif

endmodule

// File: tb/tb_atm_rx_cell_filter.sv
// Directed bench for atm_rx_cell_filter: PHY cell driver plus a byte-level output scoreboard.
module tb_atm_rx_cell_filter;
    localparam int unsigned CNT_W = 16;

    typedef struct packed {
        logic [7:0] data;
        logic       soc;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst;
    logic [CNT_W-1:0] cell_cnt;
    logic [CNT_W-1:0] hec_err_cnt;
    logic [CNT_W-1:0] runt_cnt;
`ifdef ATM_RX_IDLE_FILTER_EN
    logic [CNT_W-1:0] idle_cnt;
`endif

    atm_rx_cell_filter_if bus ();

    atm_rx_cell_filter #(.CNT_W(CNT_W)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .cell_cnt   (cell_cnt),
        .hec_err_cnt(hec_err_cnt),
        .runt_cnt   (runt_cnt)
`ifdef ATM_RX_IDLE_FILTER_EN
        ,
        .idle_cnt   (idle_cnt)
`endif
    );

    always #5 clk = ~clk;

    exp_t       sb[$];
    logic [7:0] tx_data[$];
    bit         tx_soc[$];
    int         n_cmp    = 0;
    int         n_err    = 0;
    int         exp_cell = 0;
    int         exp_hec  = 0;
    int         exp_runt = 0;
    int         exp_idle = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Bit-serial HEC reference: CRC-8 (0x07), init 0, MSB first, then XOR 0x55.
    function automatic logic [7:0] hec_of(input logic [31:0] hdr);
        logic [7:0] r;
        logic       fb;
        r = 8'h00;
        for (int i = 31; i >= 0; i--) begin
            fb = r[7] ^ hdr[i];
            r  = {r[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return r ^ 8'h55;
    endfunction

    task automatic add_cell(input logic [31:0] hdr, input logic [7:0] hec,
                            input logic [7:0] p0, input logic [7:0] step, input bit expect_out);
        logic [7:0] b;
        exp_t       e;
        for (int i = 0; i < 53; i++) begin
            if (i < 4)       b = hdr[31-8*i -: 8];
            else if (i == 4) b = hec;
            else             b = 8'(int'(p0) + int'(step) * (i - 5));
            tx_data.push_back(b);
            tx_soc.push_back(i == 0);
            if (expect_out) begin
                e.data = b;
                e.soc  = (i == 0);
                sb.push_back(e);
            end
        end
    endtask

    task automatic add_prefix(input int n);
        for (int i = 0; i < n; i++) begin
            tx_data.push_back(8'(8'hA0 + i));
            tx_soc.push_back(i == 0);
        end
    endtask

    // Present queued bytes one per enabled edge; limit < 0 sends everything.
    task automatic phy_send(input int limit);
        int i         = 0;
        int wait_cyc  = 0;
        int n;
        bit timed_out = 1'b0;
        n = (limit < 0 || limit > tx_data.size()) ? tx_data.size() : limit;
        bus.rx_clav = 1'b1;
        while (i < n && !timed_out) begin
            if (bus.rx_en_n === 1'b0) begin
                bus.rx_data = tx_data[i];
                bus.rx_soc  = tx_soc[i];
                i++;
                wait_cyc = 0;
            end else begin
                bus.rx_data = 8'h00;
                bus.rx_soc  = 1'b0;
                wait_cyc++;
                timed_out = (wait_cyc > 300);
            end
            @(posedge clk); #1;
        end
        bus.rx_clav = 1'b0;
        bus.rx_soc  = 1'b0;
        bus.rx_data = 8'h00;
        tx_data.delete();
        tx_soc.delete();
        chk("phy_wait_timeout", 32'(timed_out), 32'(0));
    endtask

    task automatic drain();
        int k = 0;
        while ((sb.size() != 0 || bus.out_valid !== 1'b0) && k < 400) begin
            @(posedge clk); #1;
            k++;
        end
        chk("drain_timeout", 32'(k >= 400), 32'(0));
    endtask

    task automatic chk_cnts();
        chk("cell_cnt", 32'(cell_cnt), 32'(exp_cell));
        chk("hec_err_cnt", 32'(hec_err_cnt), 32'(exp_hec));
        chk("runt_cnt", 32'(runt_cnt), 32'(exp_runt));
`ifdef ATM_RX_IDLE_FILTER_EN
        chk("idle_cnt", 32'(idle_cnt), 32'(exp_idle));
`endif
    endtask

    // Output monitor: every transferred byte must match the head of the scoreboard.
    always @(negedge clk) begin
        exp_t e;
        if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("out_unexpected", 32'(bus.out_valid), 32'(0));
            end else begin
                e = sb.pop_front();
                chk("out_data", 32'(bus.out_data), 32'(e.data));
                chk("out_soc", 32'(bus.out_soc), 32'(e.soc));
            end
        end
    end

    initial begin
        int gaps;
        rst           = 1'b1;
        bus.rx_data   = 8'h00;
        bus.rx_soc    = 1'b0;
        bus.rx_clav   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        chk("rst_rx_en_n", 32'(bus.rx_en_n), 32'(1));
        chk("rst_out_valid", 32'(bus.out_valid), 32'(0));
        chk("rst_out_soc", 32'(bus.out_soc), 32'(0));
        chk("rst_out_data", 32'(bus.out_data), 32'(0));
        chk_cnts();

        // Single good cell, one-cycle latency after byte 52
        bus.out_ready = 1'b1;
        add_cell(32'h12345678, hec_of(32'h12345678), 8'h00, 8'h01, 1'b1);
        phy_send(-1);
        exp_cell++;
        chk("t1_valid_latency", 32'(bus.out_valid), 32'(1));
        chk("t1_first_soc", 32'(bus.out_soc), 32'(1));
        chk("t1_first_data", 32'(bus.out_data), 32'(8'h12));
        chk("t1_rx_en_n", 32'(bus.rx_en_n), 32'(1));
        drain();
        chk_cnts();

        // Bad HEC dropped
        add_cell(32'h12345678, 8'h0D, 8'h00, 8'h01, 1'b0);
        phy_send(-1);
        exp_hec++;
        chk("t2_rx_en_n", 32'(bus.rx_en_n), 32'(1));
        chk("t2_no_valid", 32'(bus.out_valid), 32'(0));
        repeat (5) @(posedge clk);
        #1;
        chk("t2_no_valid_later", 32'(bus.out_valid), 32'(0));
        chk_cnts();

        // Runt: SOC at byte 20, then a full good cell
        add_prefix(20);
        add_cell(32'h0A0B0C0D, hec_of(32'h0A0B0C0D), 8'h80, 8'h03, 1'b1);
        phy_send(-1);
        exp_runt++;
        exp_cell++;
        drain();
        chk_cnts();

        // Idle cell
`ifdef ATM_RX_IDLE_FILTER_EN
        add_cell(32'h00000001, 8'h52, 8'h6A, 8'h00, 1'b0);
        phy_send(-1);
        exp_idle++;
        chk("idle_no_valid", 32'(bus.out_valid), 32'(0));
`else
        add_cell(32'h00000001, 8'h52, 8'h6A, 8'h00, 1'b1);
        phy_send(-1);
        exp_cell++;
        chk("idle_valid", 32'(bus.out_valid), 32'(1));
`endif
        drain();
        chk_cnts();

        // Backpressure: two cells fill the buffer, third waits for a free slot
        bus.out_ready = 1'b0;
        add_cell(32'h11111111, hec_of(32'h11111111), 8'h10, 8'h01, 1'b1);
        phy_send(-1);
        add_cell(32'h22222222, hec_of(32'h22222222), 8'h40, 8'h02, 1'b1);
        phy_send(-1);
        bus.rx_clav = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("t4_full_rx_en_n", 32'(bus.rx_en_n), 32'(1));
        chk("t4_full_valid", 32'(bus.out_valid), 32'(1));
        bus.out_ready = 1'b1;
        gaps = 0;
        for (int k = 1; k <= 106; k++) begin
            @(posedge clk); #1;
            if (k <= 105 && bus.out_valid !== 1'b1) gaps++;
            if (k == 53) chk("t4_rx_en_n_at_free", 32'(bus.rx_en_n), 32'(1));
            if (k == 54) chk("t4_rx_en_n_after_free", 32'(bus.rx_en_n), 32'(0));
        end
        chk("t4_b2b_gaps", 32'(gaps), 32'(0));
        add_cell(32'h33333333, hec_of(32'h33333333), 8'hC0, 8'h05, 1'b1);
        phy_send(-1);
        exp_cell += 3;
        drain();
        chk_cnts();

        // Reset mid-cell with one cell buffered
        bus.out_ready = 1'b0;
        add_cell(32'h44444444, hec_of(32'h44444444), 8'h01, 8'h01, 1'b1);
        phy_send(-1);
        add_cell(32'h55555555, hec_of(32'h55555555), 8'h02, 8'h01, 1'b0);
        phy_send(30);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        sb.delete();
        exp_cell = 0;
        exp_hec  = 0;
        exp_runt = 0;
        exp_idle = 0;
        chk("t5_valid", 32'(bus.out_valid), 32'(0));
        chk("t5_rx_en_n", 32'(bus.rx_en_n), 32'(1));
        chk_cnts();
        bus.out_ready = 1'b1;
        add_cell(32'h66666666, hec_of(32'h66666666), 8'h20, 8'h07, 1'b1);
        phy_send(-1);
        exp_cell++;
        chk("t5_post_valid", 32'(bus.out_valid), 32'(1));
        drain();
        chk_cnts();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
